// File: rtl/forward_select_unit_pkg.sv
// Shared types for the EX-stage operand-forwarding select logic.
// Covers the mux select codes, the stall FSM states and the nearest-stage priority pick.
package forward_select_unit_pkg;

    typedef enum logic [1:0] {
        FWD_REG    = 2'd0,
        FWD_EXMEM  = 2'd1,
        FWD_MEMWB  = 2'd2,
        FWD_WBTHRU = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } fsm_state_e;

    localparam int unsigned SB_DEPTH = 3;

    // Bit 0 is the EX entry; the nearest producing stage wins.
    function automatic fwd_sel_e fwd_pick(input logic [SB_DEPTH-1:0] hit);
        fwd_sel_e sel;
        if (hit[0])      sel = FWD_EXMEM;
        else if (hit[1]) sel = FWD_MEMWB;
        else if (hit[2]) sel = FWD_WBTHRU;
        else             sel = FWD_REG;
        return sel;
    endfunction

endpackage

// File: rtl/forward_select_unit_scoreboard.sv
// Three-deep destination scoreboard (EX, MEM, WB).
// Reports per-source producer matches and the EX entry's load status.
module forward_select_unit_scoreboard
    import forward_select_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_push,
    input  logic                  i_regwrite,
    input  logic                  i_memread,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [REG_ADDR_W-1:0] i_rt,
    output logic [SB_DEPTH-1:0]   o_hit_a,
    output logic [SB_DEPTH-1:0]   o_hit_b,
    output logic                  o_e0_load,
    output logic [REG_ADDR_W-1:0] o_e0_rd
);

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memread;
        logic [REG_ADDR_W-1:0] rd;
    } sb_entry_t;

    sb_entry_t r_ent [SB_DEPTH];
    sb_entry_t w_new;

    always_comb begin
        w_new = '0;
        if (i_push) begin
            w_new.valid    = 1'b1;
            w_new.regwrite = i_regwrite;
            w_new.memread  = i_memread;
            w_new.rd       = i_rd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ent[0] <= '0;
            r_ent[1] <= '0;
            r_ent[2] <= '0;
        end else begin
            r_ent[0] <= w_new;
            r_ent[1] <= r_ent[0];
            r_ent[2] <= r_ent[1];
        end
    end

    // $0 is never forwarded, so a zero source never matches.
    function automatic logic src_hit(input sb_entry_t e, input logic [REG_ADDR_W-1:0] s);
        return e.valid & e.regwrite & (e.rd == s) & (s != '0);
    endfunction

    always_comb begin
        o_hit_a = {src_hit(r_ent[2], i_rs), src_hit(r_ent[1], i_rs), src_hit(r_ent[0], i_rs)};
        o_hit_b = {src_hit(r_ent[2], i_rt), src_hit(r_ent[1], i_rt), src_hit(r_ent[0], i_rt)};
    end

    assign o_e0_load = r_ent[0].valid & r_ent[0].memread;
    assign o_e0_rd   = r_ent[0].rd;

endmodule

// File: rtl/forward_select_unit.sv
// Operand-mux select generation for the EX stage.
// Also inserts a single-cycle load-use bubble and counts load-use stalls.
module forward_select_unit
    import forward_select_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  ex_valid_o,
    output logic [1:0]            fwd_a_sel_o,
    output logic [1:0]            fwd_b_sel_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    fsm_state_e            r_state;
    fsm_state_e            w_state_nxt;
    logic                  r_ex_valid;
    fwd_sel_e              r_fwd_a;
    fwd_sel_e              r_fwd_b;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic [SB_DEPTH-1:0]   w_hit_a;
    logic [SB_DEPTH-1:0]   w_hit_b;
    logic                  w_e0_load;
    logic [REG_ADDR_W-1:0] w_e0_rd;
    logic                  w_hz;
    logic                  w_stall;
    logic                  w_issue;

    forward_select_unit_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_push     (w_issue),
        .i_regwrite (id_regwrite_i),
        .i_memread  (id_memread_i),
        .i_rd       (id_rd_i),
        .i_rs       (id_rs_i),
        .i_rt       (id_rt_i),
        .o_hit_a    (w_hit_a),
        .o_hit_b    (w_hit_b),
        .o_e0_load  (w_e0_load),
        .o_e0_rd    (w_e0_rd)
    );

    // Flush outranks the hazard; STALL state blocks a repeat stall on the same load.
    always_comb begin
        w_hz    = id_valid_i & w_e0_load & (w_e0_rd != '0) &
                  ((w_e0_rd == id_rs_i) | (w_e0_rd == id_rt_i));
        w_stall = w_hz & ~flush_i & (r_state == ST_RUN);
        w_issue = id_valid_i & ~flush_i & ~w_stall;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_stall) w_state_nxt = ST_STALL;
            ST_STALL: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= ST_RUN;
            r_ex_valid  <= 1'b0;
            r_fwd_a     <= FWD_REG;
            r_fwd_b     <= FWD_REG;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ex_valid <= w_issue;
            r_fwd_a    <= w_issue ? fwd_pick(w_hit_a) : FWD_REG;
            r_fwd_b    <= w_issue ? fwd_pick(w_hit_b) : FWD_REG;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign stall_o     = w_stall;
    assign ex_valid_o  = r_ex_valid;
    assign fwd_a_sel_o = r_fwd_a;
    assign fwd_b_sel_o = r_fwd_b;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_forward_select_unit.sv
// Self-checking bench for forward_select_unit: directed vector table, hand-written
// reset/saturation sequences and randomized traffic against a pipeline-history model.
module tb_forward_select_unit;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk;
    logic       rst_i;
    logic       id_valid_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic [4:0] id_rd_i;
    logic       id_regwrite_i;
    logic       id_memread_i;
    logic       flush_i;
    logic       stall_o;
    logic       ex_valid_o;
    logic [1:0] fwd_a_sel_o;
    logic [1:0] fwd_b_sel_o;
    logic [CNT_W-1:0] stall_cnt_o;

    forward_select_unit #(
        .REG_ADDR_W (5),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .ex_valid_o    (ex_valid_o),
        .fwd_a_sel_o   (fwd_a_sel_o),
        .fwd_b_sel_o   (fwd_b_sel_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rs;
        bit [4:0] rt;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
        bit       fl;
    } stim_t;

    typedef struct {
        stim_t    s;
        bit       stall;
        bit       exv;
        bit [1:0] a;
        bit [1:0] b;
        int       cnt;
    } vec_t;

    typedef struct {
        bit       v;
        bit       wr;
        bit       ld;
        bit [4:0] rd;
    } inst_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: history of what sat in EX, MEM, WB (index 0 = EX), newest first.
    inst_t hist [3];
    bit    m_prev_stall;
    bit    m_exv;
    int    m_a;
    int    m_b;
    int    m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int src_sel(input bit [4:0] s);
        if (s == 0) return 0;
        for (int k = 0; k < 3; k++) begin
            if (hist[k].v && hist[k].wr && hist[k].rd == s) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit model_stall(input stim_t s);
        return s.v && !s.fl && !m_prev_stall && hist[0].v && hist[0].ld &&
               hist[0].rd != 0 && (hist[0].rd == s.rs || hist[0].rd == s.rt);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) hist[k] = '{v: 0, wr: 0, ld: 0, rd: 0};
        m_prev_stall = 0;
        m_exv = 0;
        m_a = 0;
        m_b = 0;
        m_cnt = 0;
    endtask

    task automatic model_commit(input stim_t s, input bit st);
        bit    issue;
        inst_t ni;
        issue = s.v && !s.fl && !st;
        m_exv = issue;
        m_a   = issue ? src_sel(s.rs) : 0;
        m_b   = issue ? src_sel(s.rt) : 0;
        if (st && m_cnt < CNT_MAX) m_cnt++;
        ni = issue ? '{v: 1, wr: s.wr, ld: s.ld, rd: s.rd} : '{v: 0, wr: 0, ld: 0, rd: 0};
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = ni;
        m_prev_stall = st;
    endtask

    // One clock: drive on negedge, check stall_o mid-cycle, check registered outputs after posedge.
    task automatic run_cycle(input stim_t s, input bit rst_n, input bit use_tab, input vec_t e);
        bit st;
        @(negedge clk);
        rst_i = rst_n;
        id_valid_i = s.v;
        id_rs_i = s.rs;
        id_rt_i = s.rt;
        id_rd_i = s.rd;
        id_regwrite_i = s.wr;
        id_memread_i = s.ld;
        flush_i = s.fl;
        #1;
        st = model_stall(s);
        chk("stall_o", int'(stall_o), use_tab ? int'(e.stall) : int'(st));
        @(posedge clk);
        if (rst_n) model_commit(s, st);
        else model_clear();
        #1;
        chk("ex_valid_o", int'(ex_valid_o), use_tab ? int'(e.exv) : int'(m_exv));
        chk("fwd_a_sel_o", int'(fwd_a_sel_o), use_tab ? int'(e.a) : m_a);
        chk("fwd_b_sel_o", int'(fwd_b_sel_o), use_tab ? int'(e.b) : m_b);
        chk("stall_cnt_o", int'(stall_cnt_o), use_tab ? e.cnt : m_cnt);
    endtask

    function automatic stim_t mk_s(input bit v, input int rs, input int rt, input int rd,
                                   input bit wr, input bit ld, input bit fl);
        stim_t s;
        s.v = v; s.rs = 5'(rs); s.rt = 5'(rt); s.rd = 5'(rd);
        s.wr = wr; s.ld = ld; s.fl = fl;
        return s;
    endfunction

    function automatic vec_t mk(input bit v, input int rs, input int rt, input int rd,
                                input bit wr, input bit ld, input bit fl,
                                input bit st, input bit exv, input int a, input int b, input int cnt);
        vec_t r;
        r.s = mk_s(v, rs, rt, rd, wr, ld, fl);
        r.stall = st; r.exv = exv; r.a = 2'(a); r.b = 2'(b); r.cnt = cnt;
        return r;
    endfunction

    vec_t  tab[$];
    vec_t  none;
    stim_t idle;

    initial begin
        none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle = mk_s(0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        id_valid_i = 0; id_rs_i = 0; id_rt_i = 0; id_rd_i = 0;
        id_regwrite_i = 0; id_memread_i = 0; flush_i = 0;
        model_clear();

        //          v rs rt rd wr ld fl  stall exv a b cnt
        tab.push_back(mk(1, 1, 2, 3, 1, 0, 0, 0, 1, 0, 0, 0));  // add $3
        tab.push_back(mk(1, 3, 0, 6, 1, 0, 0, 0, 1, 1, 0, 0));  // rs=$3 from EX/MEM
        tab.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0));  // write $5 x3
        tab.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 5, 5, 7, 1, 0, 0, 0, 1, 1, 1, 0));  // nearest wins
        tab.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0));  // write $5
        tab.push_back(mk(1, 0, 0, 8, 1, 0, 0, 0, 1, 0, 0, 0));  // gap
        tab.push_back(mk(1, 5, 1, 9, 1, 0, 0, 0, 1, 2, 0, 0));  // one gap -> MEM/WB
        tab.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0));  // write $5
        tab.push_back(mk(1, 0, 0, 10, 1, 0, 0, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 0, 0, 11, 1, 0, 0, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 0, 5, 12, 1, 0, 0, 0, 1, 0, 3, 0)); // two gaps -> WB thru
        tab.push_back(mk(1, 0, 0, 4, 1, 1, 0, 0, 1, 0, 0, 0));  // lw $4
        tab.push_back(mk(1, 4, 2, 13, 1, 0, 0, 1, 0, 0, 0, 1)); // load-use stall
        tab.push_back(mk(1, 4, 2, 13, 1, 0, 0, 0, 1, 2, 0, 1)); // issues after bubble
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tab.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1));  // write $0
        tab.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 1, 0, 0, 1));  // read $0
        tab.push_back(mk(1, 0, 0, 6, 1, 1, 0, 0, 1, 0, 0, 1));  // lw $6
        tab.push_back(mk(1, 6, 0, 14, 1, 0, 1, 0, 0, 0, 0, 1)); // flushed dependent
        tab.push_back(mk(1, 6, 0, 14, 1, 0, 0, 0, 1, 2, 0, 1)); // EX holds flushed bubble
        tab.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1));  // lw $0
        tab.push_back(mk(1, 0, 0, 15, 1, 0, 0, 0, 1, 0, 0, 1)); // no stall on $0
        tab.push_back(mk(1, 0, 0, 7, 1, 1, 0, 0, 1, 0, 0, 1));  // lw $7
        tab.push_back(mk(1, 1, 7, 16, 1, 0, 0, 1, 0, 0, 0, 2)); // hazard via rt
        tab.push_back(mk(1, 1, 7, 16, 1, 0, 0, 0, 1, 0, 2, 2));
        tab.push_back(mk(1, 0, 0, 8, 1, 1, 0, 0, 1, 0, 0, 2));  // lw $8
        tab.push_back(mk(0, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 2));  // invalid ID never stalls

        // Reset held two cycles, then released.
        run_cycle(idle, 0, 1, none);
        run_cycle(idle, 0, 1, none);
        run_cycle(idle, 1, 1, none);

        foreach (tab[i]) run_cycle(tab[i].s, 1, 1, tab[i]);

        // Counter saturation: five load-use pairs.
        run_cycle(idle, 0, 0, none);
        for (int k = 1; k <= 5; k++) begin
            run_cycle(mk_s(1, 0, 0, k, 1, 1, 0), 1, 0, none);
            run_cycle(mk_s(1, k, 0, 20, 1, 0, 0), 1, 0, none);
            run_cycle(mk_s(1, k, 0, 20, 1, 0, 0), 1, 0, none);
        end
        chk("sat_cnt", int'(stall_cnt_o), CNT_MAX);

        // Reset asserted during the stall cycle discards the pending load.
        run_cycle(mk_s(1, 0, 0, 4, 1, 1, 0), 1, 0, none);
        run_cycle(mk_s(1, 4, 0, 21, 1, 0, 0), 0, 1, mk(1, 4, 0, 21, 1, 0, 0, 1, 0, 0, 0, 0));
        run_cycle(mk_s(1, 4, 0, 21, 1, 0, 0), 1, 1, mk(1, 4, 0, 21, 1, 0, 0, 0, 1, 0, 0, 0));
        run_cycle(mk_s(1, 0, 0, 4, 1, 1, 0), 1, 1, mk(1, 0, 0, 4, 1, 1, 0, 0, 1, 0, 0, 0));
        run_cycle(mk_s(1, 4, 0, 22, 1, 0, 0), 1, 1, mk(1, 4, 0, 22, 1, 0, 0, 1, 0, 0, 0, 1));

        // Randomized traffic against the history model, small register range for frequent hits.
        for (int n = 0; n < 600; n++) begin
            stim_t s;
            bit    rn;
            s.v  = ($urandom_range(99) < 85);
            s.rs = 5'($urandom_range(7));
            s.rt = 5'($urandom_range(7));
            s.rd = 5'($urandom_range(7));
            s.wr = ($urandom_range(99) < 80);
            s.ld = ($urandom_range(99) < 35);
            s.fl = ($urandom_range(99) < 10);
            rn   = ($urandom_range(199) != 0);
            run_cycle(s, rn, 0, none);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
